// File: rtl/jpeg_ctrl_pkg.sv
// rtl/jpeg_ctrl_pkg.sv - shared types and constants for the JPEG block sequencer
// Purpose: state encoding, block geometry and default stage latencies.
//          The encoder top and the bench reuse these constants.
// Ports:   none (package)
package jpeg_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_PAR,
        LOAD_SER,
        DCT,
        CAPT,
        QUANT,
        HUFF,
        DONE
    } state_t;

    localparam int BLOCK_PIXELS      = 64;
    localparam int BLOCK_ROWS        = 8;
    localparam int DEF_DCT_LATENCY   = 8;
    localparam int DEF_QUANT_LATENCY = 2;

endpackage

// File: rtl/jpeg_stage_timer.sv
// rtl/jpeg_stage_timer.sv - loadable down-counter with zero flag
// Purpose: shared wait timer for the DCT run, the per-row quantize wait and
//          the single huff_start cycle. Counts down every cycle and holds at 0.
// Ports:   clock, reset_n   clock and asynchronous active-low reset
//          load, load_value load takes priority over counting
//          zero             count is 0
module jpeg_stage_timer #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic             zero
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_value;
        end else if (count_q != '0) begin
            count_d = count_q - WIDTH'(1);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero = (count_q == '0);

endmodule

// File: rtl/jpeg_block_sequencer.sv
// rtl/jpeg_block_sequencer.sv - per-block stage sequencer for the JPEG encoder
// Purpose: walks one 8x8 block through load, DCT, capture, quantize/zigzag and
//          Huffman encode, producing all stage strobes and the row index.
// Ports:   clock, reset_n                 clock, asynchronous active-low reset
//          start, load_serial, lum_in     host block request and its options
//          abort                          synchronous abort to IDLE
//          pix_valid, pix_ready           serial pixel handshake
//          huff_done, huff_start          Huffman controller handshake
//          ready, block_done, block_count host status
//          input_enable, input_1pix_enable, dct_enable, dct_input_enable,
//          matrix_row, zigzag_input_enable, is_luminance   datapath controls
module jpeg_block_sequencer
    import jpeg_ctrl_pkg::*;
#(
    parameter int DCT_LATENCY   = DEF_DCT_LATENCY,
    parameter int QUANT_LATENCY = DEF_QUANT_LATENCY,
    parameter int CNT_WIDTH     = 16
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic                 load_serial,
    input  logic                 lum_in,
    input  logic                 abort,
    input  logic                 pix_valid,
    output logic                 pix_ready,
    input  logic                 huff_done,
    output logic                 ready,
    output logic                 input_enable,
    output logic                 input_1pix_enable,
    output logic                 dct_enable,
    output logic                 dct_input_enable,
    output logic [7:0]           matrix_row,
    output logic                 zigzag_input_enable,
    output logic                 is_luminance,
    output logic                 huff_start,
    output logic                 block_done,
    output logic [CNT_WIDTH-1:0] block_count
);

    state_t               state_q, state_d;
    logic [5:0]           pix_cnt_q, pix_cnt_d;
    logic [2:0]           row_q, row_d;
    logic                 is_lum_q, is_lum_d;
    logic [CNT_WIDTH-1:0] block_count_q, block_count_d;

    logic                 timer_load;
    logic [7:0]           timer_value;
    logic                 timer_zero;

    jpeg_stage_timer #(.WIDTH(8)) u_timer (
        .clock      (clock),
        .reset_n    (reset_n),
        .load       (timer_load),
        .load_value (timer_value),
        .zero       (timer_zero)
    );

    always_comb begin
        state_d       = state_q;
        pix_cnt_d     = pix_cnt_q;
        row_d         = row_q;
        is_lum_d      = is_lum_q;
        block_count_d = block_count_q;
        timer_load    = 1'b0;
        timer_value   = 8'd0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    is_lum_d  = lum_in;
                    pix_cnt_d = 6'd0;
                    state_d   = load_serial ? LOAD_SER : LOAD_PAR;
                end
            end
            LOAD_PAR: begin
                state_d     = DCT;
                timer_load  = 1'b1;
                timer_value = 8'(DCT_LATENCY - 1);
            end
            LOAD_SER: begin
                if (pix_valid) begin
                    pix_cnt_d = pix_cnt_q + 6'd1;
                    if (pix_cnt_q == 6'(BLOCK_PIXELS - 1)) begin
                        state_d     = DCT;
                        timer_load  = 1'b1;
                        timer_value = 8'(DCT_LATENCY - 1);
                    end
                end
            end
            DCT: begin
                if (timer_zero) begin
                    state_d = CAPT;
                end
            end
            CAPT: begin
                state_d     = QUANT;
                row_d       = 3'd0;
                timer_load  = 1'b1;
                timer_value = 8'(QUANT_LATENCY);
            end
            QUANT: begin
                // Timer reaching zero marks the strobe cycle of the current row.
                if (timer_zero) begin
                    timer_load = 1'b1;
                    if (row_q == 3'(BLOCK_ROWS - 1)) begin
                        state_d     = HUFF;
                        row_d       = 3'd0;
                        timer_value = 8'd1;
                    end else begin
                        row_d       = row_q + 3'd1;
                        timer_value = 8'(QUANT_LATENCY);
                    end
                end
            end
            HUFF: begin
                // Timer is nonzero only during the huff_start cycle.
                if (timer_zero && huff_done) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                block_count_d = block_count_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
                state_d       = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (abort) begin
            state_d       = IDLE;
            row_d         = 3'd0;
            pix_cnt_d     = 6'd0;
            is_lum_d      = is_lum_q;
            block_count_d = block_count_q;
            timer_load    = 1'b1;
            timer_value   = 8'd0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            pix_cnt_q     <= 6'd0;
            row_q         <= 3'd0;
            is_lum_q      <= 1'b0;
            block_count_q <= '0;
        end else begin
            state_q       <= state_d;
            pix_cnt_q     <= pix_cnt_d;
            row_q         <= row_d;
            is_lum_q      <= is_lum_d;
            block_count_q <= block_count_d;
        end
    end

    assign ready               = (state_q == IDLE);
    assign input_enable        = (state_q == LOAD_PAR);
    assign pix_ready           = (state_q == LOAD_SER);
    assign input_1pix_enable   = pix_valid & pix_ready;
    assign dct_enable          = (state_q == DCT);
    assign dct_input_enable    = (state_q == CAPT);
    assign matrix_row          = {5'd0, row_q};
    assign zigzag_input_enable = (state_q == QUANT) && timer_zero;
    assign huff_start          = (state_q == HUFF) && !timer_zero;
    assign block_done          = (state_q == DONE);
    assign is_luminance        = is_lum_q;
    assign block_count         = block_count_q;

endmodule

// File: tb/tb_jpeg_block_sequencer.sv
// tb/tb_jpeg_block_sequencer.sv - self-checking bench for jpeg_block_sequencer
module tb_jpeg_block_sequencer;
    import jpeg_ctrl_pkg::*;

    logic        clock = 1'b0;
    logic        reset_n, start, load_serial, lum_in, abort, pix_valid, huff_done;
    logic        pix_ready, ready, input_enable, input_1pix_enable, dct_enable;
    logic        dct_input_enable, zigzag_input_enable, is_luminance, huff_start, block_done;
    logic [7:0]  matrix_row;
    logic [15:0] block_count;

    int n_cmp = 0;
    int n_bad = 0;

    jpeg_block_sequencer dut (
        .clock(clock), .reset_n(reset_n), .start(start), .load_serial(load_serial),
        .lum_in(lum_in), .abort(abort), .pix_valid(pix_valid), .pix_ready(pix_ready),
        .huff_done(huff_done), .ready(ready), .input_enable(input_enable),
        .input_1pix_enable(input_1pix_enable), .dct_enable(dct_enable),
        .dct_input_enable(dct_input_enable), .matrix_row(matrix_row),
        .zigzag_input_enable(zigzag_input_enable), .is_luminance(is_luminance),
        .huff_start(huff_start), .block_done(block_done), .block_count(block_count)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        start;
        logic        huff_done;
        logic [33:0] exp;
    } vec_t;

    vec_t tbl[43];

    function automatic logic [33:0] pk(input logic rdy, input logic ie, input logic i1,
                                       input logic pr, input logic de, input logic ce,
                                       input logic [7:0] row, input logic zz, input logic hs,
                                       input logic bd, input logic lum, input logic [15:0] cnt);
        return {rdy, ie, i1, pr, de, ce, row, zz, hs, bd, lum, cnt};
    endfunction

    function automatic logic [33:0] obs();
        return pk(ready, input_enable, input_1pix_enable, pix_ready, dct_enable,
                  dct_input_enable, matrix_row, zigzag_input_enable, huff_start,
                  block_done, is_luminance, block_count);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic finish_block(input string tag);
        for (int i = 0; i < 100 && !huff_start; i++) step();
        chk({tag, "_huff_start"}, huff_start, 1);
        step();
        huff_done = 1'b1;
        step();
        huff_done = 1'b0;
        chk({tag, "_block_done"}, block_done, 1);
        step();
    endtask

    initial begin
        int acc, last, dct_at, ie_cnt, zz_cnt, hs_cnt, bd_cnt;
        logic [15:0] cnt_before;

        reset_n = 1'b0; start = 0; load_serial = 0; lum_in = 0;
        abort = 0; pix_valid = 0; huff_done = 0;
        repeat (2) @(posedge clock);
        #1;
        chk("reset_state", obs(), pk(1, 0, 0, 0, 0, 0, 8'd0, 0, 0, 0, 0, 16'd0));
        reset_n = 1'b1;
        step();

        // Parallel block: expected strobe cycles relative to the start edge.
        for (int c = 0; c < 43; c++) begin
            logic       zz;
            logic [7:0] row;
            zz  = (c >= 13) && (c <= 34) && ((c - 13) % 3 == 0);
            row = (c >= 11 && c <= 34) ? 8'((c - 11) / 3) : 8'd0;
            tbl[c].start     = (c == 0);
            tbl[c].huff_done = (c == 40);
            tbl[c].exp = pk((c == 0) || (c >= 42), c == 1, 0, 0, (c >= 2 && c <= 9),
                            c == 10, row, zz, c == 35, c == 41, c >= 1,
                            (c >= 42) ? 16'd1 : 16'd0);
        end
        lum_in = 1'b1;
        load_serial = 1'b0;
        for (int c = 0; c < 43; c++) begin
            start     = tbl[c].start;
            huff_done = tbl[c].huff_done;
            #1;
            chk($sformatf("par_cycle%0d", c), obs(), tbl[c].exp);
            step();
        end
        start = 0; huff_done = 0;

        // Serial block with pix_valid low every 4th cycle.
        load_serial = 1'b1;
        lum_in = 1'b0;
        pulse_start();
        acc = 0; last = -1; dct_at = -1; ie_cnt = 0;
        for (int i = 0; i < 200; i++) begin
            pix_valid = ((i % 4) != 3);
            #1;
            if (input_1pix_enable) begin
                acc++;
                if (acc == 64) last = i;
            end
            if (input_enable) ie_cnt++;
            if (dct_enable && dct_at < 0) dct_at = i;
            step();
            if (dct_at >= 0) break;
        end
        chk("ser_accepts", acc, 64);
        chk("ser_no_par_load", ie_cnt, 0);
        chk("ser_dct_after_last", dct_at, last + 1);
        pix_valid = 1'b1;
        #1;
        chk("ser_pix_ignored_in_dct", {pix_ready, input_1pix_enable}, 2'b00);
        chk("ser_is_lum", is_luminance, 0);
        pix_valid = 1'b0;
        load_serial = 1'b0;
        finish_block("ser");
        chk("ser_count", block_count, 2);

        // Abort during QUANT at row 3.
        lum_in = 1'b1;
        pulse_start();
        for (int i = 0; i < 100 && matrix_row != 8'd3; i++) step();
        chk("abort_reach_row3", matrix_row, 3);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abort_state", {ready, matrix_row, zigzag_input_enable, is_luminance}, {1'b1, 8'd0, 1'b0, 1'b1});
        zz_cnt = 0; hs_cnt = 0; bd_cnt = 0;
        for (int i = 0; i < 60; i++) begin
            if (zigzag_input_enable) zz_cnt++;
            if (huff_start) hs_cnt++;
            if (block_done) bd_cnt++;
            step();
        end
        chk("abort_no_followups", {zz_cnt[7:0], hs_cnt[7:0], bd_cnt[7:0]}, 24'd0);
        chk("abort_count", block_count, 2);

        // start pulsed during DCT and during DONE must be ignored.
        pulse_start();
        for (int i = 0; i < 20 && !dct_enable; i++) step();
        chk("ign_reach_dct", dct_enable, 1);
        pulse_start();
        for (int i = 0; i < 100 && !huff_start; i++) step();
        step();
        huff_done = 1'b1;
        step();
        huff_done = 1'b0;
        chk("ign_done_cycle", block_done, 1);
        pulse_start();
        step();
        chk("ign_still_idle", {ready, input_enable, block_done}, 3'b100);
        chk("ign_count_once", block_count, 3);
        pulse_start();
        finish_block("fresh");
        chk("fresh_count", block_count, 4);

        // huff_done coincident with huff_start is ignored.
        pulse_start();
        for (int i = 0; i < 100 && !huff_start; i++) step();
        chk("hd_reach_hs", huff_start, 1);
        huff_done = 1'b1;
        step();
        huff_done = 1'b0;
        bd_cnt = 0;
        for (int k = 1; k < 5; k++) begin
            if (block_done) bd_cnt++;
            step();
        end
        chk("hd_early_ignored", bd_cnt, 0);
        huff_done = 1'b1;
        step();
        huff_done = 1'b0;
        chk("hd_late_done", block_done, 1);
        step();
        chk("hd_count", block_count, 5);

        // Counter wrap from all-ones.
        force dut.block_count_q = 16'hFFFF;
        step();
        release dut.block_count_q;
        #1;
        chk("wrap_preload", block_count, 16'hFFFF);
        pulse_start();
        finish_block("wrap");
        chk("wrap_count", block_count, 0);

        // Reset asserted mid-DCT.
        pulse_start();
        for (int i = 0; i < 20 && !dct_enable; i++) step();
        chk("rst_reach_dct", dct_enable, 1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("rst_mid_dct", obs(), pk(1, 0, 0, 0, 0, 0, 8'd0, 0, 0, 0, 0, 16'd0));
        step();
        reset_n = 1'b1;
        step();
        chk("rst_idle_after", ready, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
